// File: rtl/best_arr_readout_if.sv
// rtl/best_arr_readout_if.sv - control, result-SRAM read and output-FIFO enqueue bundle
//
// Purpose: groups the handshake and bus signals of best_arr_readout.
// Ports (master = readout engine side):
//   start, raster_mode        -> request to stream, order select
//   busy, done                <- stream status
//   mem_ren, mem_raddr        <- result SRAM read strobe and address
//   mem_rdata                 -> SRAM data, one cycle after mem_ren
//   out_wenq, out_wdata       <- output FIFO enqueue
//   out_wfull_n               -> FIFO not-full
interface best_arr_readout_if #(
  parameter int DATA_WIDTH = 11,
  parameter int ADDR_WIDTH = 9
);
  logic                  start;
  logic                  raster_mode;
  logic                  busy;
  logic                  done;
  logic                  mem_ren;
  logic [ADDR_WIDTH-1:0] mem_raddr;
  logic [DATA_WIDTH-1:0] mem_rdata;
  logic                  out_wenq;
  logic [DATA_WIDTH-1:0] out_wdata;
  logic                  out_wfull_n;

  modport master (
    input  start, raster_mode, mem_rdata, out_wfull_n,
    output busy, done, mem_ren, mem_raddr, out_wenq, out_wdata
  );

  modport slave (
    output start, raster_mode, mem_rdata, out_wfull_n,
    input  busy, done, mem_ren, mem_raddr, out_wenq, out_wdata
  );
endinterface

// File: rtl/best_arr_readout.sv
// rtl/best_arr_readout.sv - streams the best-match result array to a FIFO in raster or blocked order
//
// Purpose: on start, reads every result word once from the result SRAM and
// enqueues it into the output FIFO, either in raster order or in column
// blocks of BLOCKING patches (all rows of a block before the next block).
// Ports:
//   clk  - sole clock, rising edge
//   rst  - synchronous active-high reset
//   bus  - best_arr_readout_if.master (start/busy/done, SRAM read, FIFO enqueue)
module best_arr_readout #(
  parameter int DATA_WIDTH = 11,
  parameter int ROW_SIZE   = 26,
  parameter int COL_SIZE   = 19,
  parameter int BLOCKING   = 4
) (
  input logic                 clk,
  input logic                 rst,
  best_arr_readout_if.master  bus
);

  localparam int NUM_QUERYS = ROW_SIZE * COL_SIZE;
  localparam int ADDR_WIDTH = $clog2(NUM_QUERYS);
  localparam int NUM_BLK    = (ROW_SIZE + BLOCKING - 1) / BLOCKING;
  localparam int LAST_W     = ROW_SIZE - (NUM_BLK - 1) * BLOCKING;

  typedef logic [ADDR_WIDTH-1:0] addr_t;

  localparam addr_t ROW_STEP      = addr_t'(ROW_SIZE);
  localparam addr_t BLK_STEP      = addr_t'(BLOCKING);
  localparam addr_t ROW_W_M1      = addr_t'(ROW_SIZE - 1);
  localparam addr_t BLK_W_M1      = addr_t'(BLOCKING - 1);
  localparam addr_t LAST_W_M1     = addr_t'(LAST_W - 1);
  localparam addr_t COL_M1        = addr_t'(COL_SIZE - 1);
  localparam addr_t LAST_BLK_BASE = addr_t'((NUM_BLK - 1) * BLOCKING);
  localparam addr_t LAST_ISSUE    = addr_t'(NUM_QUERYS - 1);

  typedef enum logic [1:0] {IDLE, STREAM, FLUSH, DONE} state_t;

  state_t state;
  logic   raster_q;
  logic   busy_q;
  logic   done_q;

  // Address is row_base + blk_base + xi; row_base tracks y*ROW_SIZE.
  addr_t row_base;
  addr_t blk_base;
  addr_t xi;
  addr_t y;
  addr_t issued;

  // Two-entry holding buffer in front of the FIFO.
  logic [DATA_WIDTH-1:0] buf_q [2];
  logic                  wr_ptr;
  logic                  rd_ptr;
  logic [1:0]            cnt;
  logic                  rvalid;   // read issued last cycle; data on mem_rdata now

  logic       deq;
  logic [2:0] pending;
  logic       issue;
  addr_t      w_m1;

  // Counting this cycle's dequeue lets a read issue every cycle in steady
  // state while still never overrunning the buffer if the FIFO stalls.
  assign deq     = (cnt != 2'd0) && bus.out_wfull_n;
  assign pending = {1'b0, cnt} + {2'b00, rvalid} - {2'b00, deq};
  assign issue   = (state == STREAM) && (pending < 3'd2);

  // Raster order is one block spanning the whole row.
  assign w_m1 = raster_q                    ? ROW_W_M1  :
                (blk_base == LAST_BLK_BASE) ? LAST_W_M1 : BLK_W_M1;

  assign bus.mem_ren   = issue;
  assign bus.mem_raddr = row_base + blk_base + xi;
  assign bus.out_wenq  = deq;
  assign bus.out_wdata = buf_q[rd_ptr];
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      buf_q[0] <= '0;
      buf_q[1] <= '0;
      wr_ptr   <= 1'b0;
      rd_ptr   <= 1'b0;
      cnt      <= 2'd0;
      rvalid   <= 1'b0;
    end else begin
      rvalid <= issue;
      if (rvalid) begin
        buf_q[wr_ptr] <= bus.mem_rdata;
        wr_ptr        <= ~wr_ptr;
      end
      if (deq) begin
        rd_ptr <= ~rd_ptr;
      end
      cnt <= cnt + {1'b0, rvalid} - {1'b0, deq};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      raster_q <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      row_base <= '0;
      blk_base <= '0;
      xi       <= '0;
      y        <= '0;
      issued   <= '0;
    end else begin
      case (state)
        IDLE: begin
          done_q <= 1'b0;
          if (bus.start) begin
            state    <= STREAM;
            raster_q <= bus.raster_mode;
            busy_q   <= 1'b1;
            row_base <= '0;
            blk_base <= '0;
            xi       <= '0;
            y        <= '0;
            issued   <= '0;
          end
        end
        STREAM: begin
          if (issue) begin
            issued <= issued + 1'b1;
            if (xi == w_m1) begin
              xi <= '0;
              if (y == COL_M1) begin
                y        <= '0;
                row_base <= '0;
                blk_base <= blk_base + BLK_STEP;
              end else begin
                y        <= y + 1'b1;
                row_base <= row_base + ROW_STEP;
              end
            end else begin
              xi <= xi + 1'b1;
            end
            if (issued == LAST_ISSUE) begin
              state <= FLUSH;
            end
          end
        end
        FLUSH: begin
          if ((cnt == 2'd0) && !rvalid) begin
            state  <= DONE;
            busy_q <= 1'b0;
            done_q <= 1'b1;
          end
        end
        DONE: begin
          done_q <= 1'b0;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_best_arr_readout.sv
// tb/tb_best_arr_readout.sv - self-checking bench for best_arr_readout
module tb_best_arr_readout;
  localparam int DW   = 11;
  localparam int AW   = 9;
  localparam int AW_S = 5;
  localparam int NQ   = 494;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  best_arr_readout_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW))   a ();
  best_arr_readout_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW_S)) b ();

  best_arr_readout #(.DATA_WIDTH(DW)) dut (.clk(clk), .rst(rst), .bus(a.master));
  best_arr_readout #(.DATA_WIDTH(DW), .ROW_SIZE(8), .COL_SIZE(3), .BLOCKING(8))
    dut_s (.clk(clk), .rst(rst), .bus(b.master));

  // Result SRAM models: each word holds its own address; all-ones when not read.
  always @(posedge clk) begin
    a.mem_rdata <= a.mem_ren ? DW'(a.mem_raddr) : {DW{1'b1}};
    b.mem_rdata <= b.mem_ren ? DW'(b.mem_raddr) : {DW{1'b1}};
  end

  int n_checks = 0;
  int n_fail   = 0;

  int got[$];
  int expq[$];
  int first_enq, done_pulses, done_at_words, max_out, full_enq, idle_act, issued;
  bit finished, rst_hit;
  logic busy_c0;
  logic rs_busy, rs_done, rs_ren, rs_wenq;
  logic [AW-1:0] rs_raddr;
  logic [DW-1:0] rs_wdata;

  task automatic build_expected(input bit raster, input int row, input int col,
                                input int blk, output int q[$]);
    q.delete();
    if (raster) begin
      for (int i = 0; i < row * col; i++) q.push_back(i);
    end else begin
      for (int xb = 0; xb * blk < row; xb++)
        for (int yy = 0; yy < col; yy++)
          for (int k = 0; k < blk && xb * blk + k < row; k++)
            q.push_back(yy * row + xb * blk + k);
    end
  endtask

  task automatic run_stream(input bit raster, input bit bp, input int perturb_at, input int rst_at);
    int tail = 0;
    int burst = 0;
    bit perturbed = 1'b0;
    got.delete();
    first_enq = -1; done_pulses = 0; done_at_words = -1; max_out = 0;
    full_enq = 0; idle_act = 0; issued = 0; finished = 1'b0; rst_hit = 1'b0; busy_c0 = 1'b0;
    @(negedge clk);
    a.start = 1'b1; a.raster_mode = raster; a.out_wfull_n = 1'b1;
    @(negedge clk);
    a.start = 1'b0;
    for (int cyc = 0; cyc < 4000; cyc++) begin
      if (bp && got.size() >= 40) begin
        if (burst < 10) begin
          a.out_wfull_n = 1'b0;
          burst++;
        end else begin
          a.out_wfull_n = 1'($urandom_range(0, 1));
        end
      end else begin
        a.out_wfull_n = 1'b1;
      end
      a.start = 1'b0;
      if (perturb_at >= 0 && !perturbed && got.size() >= perturb_at) begin
        a.start = 1'b1;
        a.raster_mode = ~a.raster_mode;
        perturbed = 1'b1;
      end
      if (rst_at >= 0 && got.size() >= rst_at) begin
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        rs_busy = a.busy; rs_done = a.done; rs_ren = a.mem_ren; rs_wenq = a.out_wenq;
        rs_raddr = a.mem_raddr; rs_wdata = a.out_wdata;
        rst_hit = 1'b1;
        a.raster_mode = 1'b0;
        return;
      end
      #1;
      if (cyc == 0) busy_c0 = a.busy;
      if (a.mem_ren) issued++;
      if (a.out_wenq) begin
        if (!a.out_wfull_n) full_enq++;
        if (first_enq < 0) first_enq = cyc;
        got.push_back(int'(a.out_wdata));
      end
      if (issued - got.size() > max_out) max_out = issued - got.size();
      if (a.done) begin
        done_pulses++;
        if (done_at_words < 0) done_at_words = got.size();
      end
      if (done_pulses > 0 && (a.mem_ren || a.out_wenq)) idle_act++;
      if (done_pulses > 0) begin
        tail++;
        if (tail >= 5) begin
          finished = 1'b1;
          break;
        end
      end
      @(negedge clk);
    end
    a.out_wfull_n = 1'b1;
    a.raster_mode = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    a.start = 1'b0; a.raster_mode = 1'b0; a.out_wfull_n = 1'b1;
    b.start = 1'b0; b.raster_mode = 1'b0; b.out_wfull_n = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    n_checks++; if (a.busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", a.busy); end
    n_checks++; if (a.done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b expected 0", a.done); end
    n_checks++; if (a.mem_ren !== 1'b0) begin n_fail++; $display("FAIL reset_mem_ren: got %b expected 0", a.mem_ren); end
    n_checks++; if (a.out_wenq !== 1'b0) begin n_fail++; $display("FAIL reset_out_wenq: got %b expected 0", a.out_wenq); end
    n_checks++; if (a.mem_raddr !== '0) begin n_fail++; $display("FAIL reset_mem_raddr: got %0d expected 0", a.mem_raddr); end
    n_checks++; if (a.out_wdata !== '0) begin n_fail++; $display("FAIL reset_out_wdata: got %0d expected 0", a.out_wdata); end
  endtask

  task automatic test_blocked();
    int idx[12] = '{0, 1, 2, 3, 4, 5, 76, 456, 457, 458, 459, 493};
    int adr[12] = '{0, 1, 2, 3, 26, 27, 4, 24, 25, 50, 51, 493};
    int bad = -1;
    run_stream(1'b0, 1'b0, -1, -1);
    n_checks++; if (!finished) begin n_fail++; $display("FAIL blocked_timeout: got no done within budget"); end
    n_checks++; if (got.size() != NQ) begin n_fail++; $display("FAIL blocked_count: got %0d expected %0d", got.size(), NQ); end
    n_checks++; if (first_enq != 2) begin n_fail++; $display("FAIL blocked_latency: got %0d expected 2", first_enq); end
    n_checks++; if (busy_c0 !== 1'b1) begin n_fail++; $display("FAIL blocked_busy: got %b expected 1", busy_c0); end
    for (int i = 0; i < 12; i++) begin
      n_checks++;
      if (got.size() <= idx[i] || got[idx[i]] != adr[i]) begin
        n_fail++;
        $display("FAIL blocked_word%0d: got %0d expected %0d", idx[i],
                 (got.size() > idx[i]) ? got[idx[i]] : -1, adr[i]);
      end
    end
    build_expected(1'b0, 26, 19, 4, expq);
    for (int i = 0; i < got.size() && i < expq.size(); i++) if (got[i] != expq[i] && bad < 0) bad = i;
    n_checks++; if (bad >= 0) begin n_fail++; $display("FAIL blocked_sequence: word %0d got %0d expected %0d", bad, got[bad], expq[bad]); end
    n_checks++; if (done_pulses != 1) begin n_fail++; $display("FAIL blocked_done_pulses: got %0d expected 1", done_pulses); end
    n_checks++; if (done_at_words != NQ) begin n_fail++; $display("FAIL blocked_done_after_last: got %0d expected %0d", done_at_words, NQ); end
    n_checks++; if (idle_act != 0) begin n_fail++; $display("FAIL blocked_idle_activity: got %0d expected 0", idle_act); end
  endtask

  task automatic test_raster();
    int bad = -1;
    run_stream(1'b1, 1'b0, -1, -1);
    n_checks++; if (got.size() != NQ) begin n_fail++; $display("FAIL raster_count: got %0d expected %0d", got.size(), NQ); end
    n_checks++; if (first_enq != 2) begin n_fail++; $display("FAIL raster_latency: got %0d expected 2", first_enq); end
    for (int i = 0; i < got.size(); i++) if (got[i] != i && bad < 0) bad = i;
    n_checks++; if (bad >= 0) begin n_fail++; $display("FAIL raster_sequence: word %0d got %0d expected %0d", bad, got[bad], bad); end
    n_checks++; if (done_pulses != 1) begin n_fail++; $display("FAIL raster_done_pulses: got %0d expected 1", done_pulses); end
  endtask

  task automatic test_backpressure();
    int bad = -1;
    run_stream(1'b0, 1'b1, -1, -1);
    n_checks++; if (!finished) begin n_fail++; $display("FAIL bp_timeout: got no done within budget"); end
    n_checks++; if (got.size() != NQ) begin n_fail++; $display("FAIL bp_count: got %0d expected %0d", got.size(), NQ); end
    n_checks++; if (full_enq != 0) begin n_fail++; $display("FAIL bp_enq_while_full: got %0d expected 0", full_enq); end
    n_checks++; if (max_out > 2) begin n_fail++; $display("FAIL bp_outstanding: got %0d expected at most 2", max_out); end
    build_expected(1'b0, 26, 19, 4, expq);
    for (int i = 0; i < got.size() && i < expq.size(); i++) if (got[i] != expq[i] && bad < 0) bad = i;
    n_checks++; if (bad >= 0) begin n_fail++; $display("FAIL bp_sequence: word %0d got %0d expected %0d", bad, got[bad], expq[bad]); end
    n_checks++; if (done_pulses != 1) begin n_fail++; $display("FAIL bp_done_pulses: got %0d expected 1", done_pulses); end
  endtask

  task automatic test_restart_ignored();
    int bad = -1;
    run_stream(1'b0, 1'b0, 100, -1);
    n_checks++; if (got.size() != NQ) begin n_fail++; $display("FAIL restart_count: got %0d expected %0d", got.size(), NQ); end
    build_expected(1'b0, 26, 19, 4, expq);
    for (int i = 0; i < got.size() && i < expq.size(); i++) if (got[i] != expq[i] && bad < 0) bad = i;
    n_checks++; if (bad >= 0) begin n_fail++; $display("FAIL restart_sequence: word %0d got %0d expected %0d", bad, got[bad], expq[bad]); end
    n_checks++; if (done_pulses != 1) begin n_fail++; $display("FAIL restart_done_pulses: got %0d expected 1", done_pulses); end
  endtask

  task automatic test_reset_mid();
    int bad = -1;
    run_stream(1'b0, 1'b0, -1, 200);
    n_checks++; if (!rst_hit) begin n_fail++; $display("FAIL midrst_reached: stream ended before word 200"); end
    n_checks++; if ({rs_busy, rs_done, rs_ren, rs_wenq} !== 4'b0000)
      begin n_fail++; $display("FAIL midrst_controls: got busy/done/ren/wenq %b expected 0000", {rs_busy, rs_done, rs_ren, rs_wenq}); end
    n_checks++; if (rs_raddr !== '0 || rs_wdata !== '0)
      begin n_fail++; $display("FAIL midrst_data: got raddr %0d wdata %0d expected 0 0", rs_raddr, rs_wdata); end
    run_stream(1'b0, 1'b0, -1, -1);
    n_checks++; if (got.size() != NQ) begin n_fail++; $display("FAIL midrst_restart_count: got %0d expected %0d", got.size(), NQ); end
    build_expected(1'b0, 26, 19, 4, expq);
    for (int i = 0; i < got.size() && i < expq.size(); i++) if (got[i] != expq[i] && bad < 0) bad = i;
    n_checks++; if (bad >= 0) begin n_fail++; $display("FAIL midrst_restart_sequence: word %0d got %0d expected %0d", bad, got[bad], expq[bad]); end
  endtask

  task automatic test_small_full_block();
    int sgot[$];
    int bad = -1;
    int dones = 0;
    @(negedge clk);
    b.start = 1'b1; b.raster_mode = 1'b0; b.out_wfull_n = 1'b1;
    @(negedge clk);
    b.start = 1'b0;
    for (int cyc = 0; cyc < 200 && dones == 0; cyc++) begin
      #1;
      if (b.out_wenq) sgot.push_back(int'(b.out_wdata));
      if (b.done) dones++;
      @(negedge clk);
    end
    n_checks++; if (dones != 1) begin n_fail++; $display("FAIL small_done: got %0d expected 1", dones); end
    n_checks++; if (sgot.size() != 24) begin n_fail++; $display("FAIL small_count: got %0d expected 24", sgot.size()); end
    for (int i = 0; i < sgot.size(); i++) if (sgot[i] != i && bad < 0) bad = i;
    n_checks++; if (bad >= 0) begin n_fail++; $display("FAIL small_sequence: word %0d got %0d expected %0d", bad, sgot[bad], bad); end
  endtask

  initial begin
    test_reset();
    test_blocked();
    test_raster();
    test_backpressure();
    test_restart_ignored();
    test_reset_mid();
    test_small_full_block();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
